cache_arbiter: RTL and testbench

//  Arbitrates the single physical-memory port between the I-cache and D-cache miss/writeback paths.

---
 rtl/cache_arbiter_pkg.sv | 28 ++
 rtl/cache_arbiter_ctrl.sv | 109 ++++++++++
 rtl/cache_arbiter.sv | 113 +++++++++++
 tb/tb_cache_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// lc3b_types: shared types for the cache/pmem arbiter.
//   lc3b_line   - one 128-bit cache line
//   lc3b_addr   - 16-bit line address
//   arb_state_t - arbiter FSM states (also the encoding seen on dbg_state)
//   arb_owner_t - which cache currently owns the pmem port
// Optional feature macro ARB_ROUND_ROBIN_EN is consumed by cache_arbiter_ctrl.
package lc3b_types;

  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_addr;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  function automatic logic arb_is_busy(input arb_state_t s);
    return (s == BUSY_I) || (s == BUSY_D);
  endfunction

endpackage

// File: rtl/cache_arbiter_ctrl.sv
// cache_arbiter_ctrl: FSM, arbitration policy and grant decode for cache_arbiter.
//   clk, reset     - clock, asynchronous active-high reset
//   i_req_i        - I-cache request level (I_pmem_read)
//   i_req_d        - D-cache request level (D_pmem_read | D_pmem_write)
//   i_pmem_resp    - physical memory completion pulse
//   o_grant        - combinational: a grant is issued this cycle (IDLE only)
//   o_grant_d      - combinational: winner of that grant is D (0 = I)
//   o_state        - current arb_state_t encoding (also used for debug)
// Policy:
//   default             - D beats I, except when the starvation counter has
//                         reached STARVE_LIMIT (non-zero), in which case I wins.
//   ARB_ROUND_ROBIN_EN  - on a tie the side that did not own last wins; no
//                         starvation counter is built.
module cache_arbiter_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req_i,
  input  logic       i_req_d,
  input  logic       i_pmem_resp,
  output logic       o_grant,
  output logic       o_grant_d,
  output logic [1:0] o_state
);

  arb_state_t r_state;
  arb_state_t w_next;
  arb_owner_t w_win;
  logic       w_grant;
  logic       w_i_wins_tie;

  // Grant decode and next state. Requests are only sampled in IDLE; anything
  // raised during BUSY_*/RELEASE simply waits at its level.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_win   = OWN_D;
    case (r_state)
      IDLE: begin
        w_grant = i_req_i | i_req_d;
        if (i_req_i && !i_req_d) begin
          w_win = OWN_I;
        end else if (i_req_i && i_req_d) begin
          w_win = w_i_wins_tie ? OWN_I : OWN_D;
        end
        if (w_grant) begin
          w_next = (w_win == OWN_I) ? BUSY_I : BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (i_pmem_resp) begin
          w_next = RELEASE;
        end
      end
      RELEASE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t r_rr_last;

  assign w_i_wins_tie = (r_rr_last == OWN_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last <= OWN_I;
    end else if (w_grant) begin
      r_rr_last <= w_win;
    end
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  // With STARVE_LIMIT == 0 the counter never leaves 0 and never forces I.
  assign w_i_wins_tie = (STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      if (w_win == OWN_I) begin
        r_starve_cnt <= '0;
      end else if (i_req_i && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`endif

  assign o_grant   = w_grant;
  assign o_grant_d = (w_win == OWN_D);
  assign o_state   = r_state;

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single pmem port between I-cache and D-cache.
// One 128-bit line transaction at a time; request fields are latched at grant
// and held on pmem_* until pmem_resp.
// Handshake: each cache holds its request level until its X_pmem_resp pulse;
// pmem holds pmem_read/pmem_write seen from us until it pulses pmem_resp for
// one cycle. The arbiter then spends one RELEASE cycle so the cache can drop
// its request before the next IDLE sample.
// Ports:
//   clk, reset                                   - clock, async active-high reset
//   I_pmem_read/address, I_pmem_rdata/resp       - I-cache side
//   D_pmem_read/write/address/wdata,
//   D_pmem_rdata/resp                            - D-cache side
//   pmem_resp/rdata, pmem_read/write/address/wdata - physical memory side
//   dbg_state                                    - arb_state_t encoding
// Parameter STARVE_LIMIT: D grants with I waiting before I is forced (0 = off).
// Macro ARB_ROUND_ROBIN_EN: replaces fixed D priority with round-robin.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         I_pmem_read,
  input  logic [15:0]  I_pmem_address,
  output logic [127:0] I_pmem_rdata,
  output logic         I_pmem_resp,
  input  logic         D_pmem_read,
  input  logic         D_pmem_write,
  input  logic [15:0]  D_pmem_address,
  input  logic [127:0] D_pmem_wdata,
  output logic [127:0] D_pmem_rdata,
  output logic         D_pmem_resp,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic [1:0]   dbg_state
);

  logic       w_grant;
  logic       w_grant_d;
  logic [1:0] w_state;
  logic       w_busy;
  logic       w_busy_i;
  logic       w_busy_d;

  logic       r_read;
  logic       r_write;
  lc3b_addr   r_addr;
  lc3b_line   r_wdata;

  cache_arbiter_ctrl #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .i_req_i    (I_pmem_read),
    .i_req_d    (D_pmem_read | D_pmem_write),
    .i_pmem_resp(pmem_resp),
    .o_grant    (w_grant),
    .o_grant_d  (w_grant_d),
    .o_state    (w_state)
  );

  assign w_busy_i = (arb_state_t'(w_state) == BUSY_I);
  assign w_busy_d = (arb_state_t'(w_state) == BUSY_D);
  assign w_busy   = arb_is_busy(arb_state_t'(w_state));

  // Transaction registers. Loaded once at grant so the caches may wiggle
  // their inputs during BUSY without disturbing pmem. A D read+write is
  // served as a write only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      if (!w_grant_d) begin
        r_read  <= 1'b1;
        r_write <= 1'b0;
        r_addr  <= I_pmem_address;
        r_wdata <= '0;
      end else begin
        r_read  <= D_pmem_read & ~D_pmem_write;
        r_write <= D_pmem_write;
        r_addr  <= D_pmem_address;
        r_wdata <= D_pmem_wdata;
      end
    end else if (w_busy && pmem_resp) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  assign pmem_read    = r_read;
  assign pmem_write   = r_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // Completion reaches only the owner, and only while BUSY: a stray
  // pmem_resp in IDLE or RELEASE goes nowhere.
  assign I_pmem_resp  = pmem_resp & w_busy_i;
  assign D_pmem_resp  = pmem_resp & w_busy_d;
  assign I_pmem_rdata = pmem_rdata;
  assign D_pmem_rdata = pmem_rdata;

  assign dbg_state    = w_state;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_I  = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic         clk;
  logic         reset;
  logic         I_pmem_read;
  logic [15:0]  I_pmem_address;
  logic [127:0] I_pmem_rdata;
  logic         I_pmem_resp;
  logic         D_pmem_read;
  logic         D_pmem_write;
  logic [15:0]  D_pmem_address;
  logic [127:0] D_pmem_wdata;
  logic [127:0] D_pmem_rdata;
  logic         D_pmem_resp;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(
    .STARVE_LIMIT(3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .I_pmem_read   (I_pmem_read),
    .I_pmem_address(I_pmem_address),
    .I_pmem_rdata  (I_pmem_rdata),
    .I_pmem_resp   (I_pmem_resp),
    .D_pmem_read   (D_pmem_read),
    .D_pmem_write  (D_pmem_write),
    .D_pmem_address(D_pmem_address),
    .D_pmem_wdata  (D_pmem_wdata),
    .D_pmem_rdata  (D_pmem_rdata),
    .D_pmem_resp   (D_pmem_resp),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_seq [5];
    logic [127:0] line_a5;
    logic [127:0] line_db;

    line_a5 = {4{32'hA5A5_A5A5}};
    line_db = {4{32'hDEAD_BEEF}};

    reset          = 1'b1;
    I_pmem_read    = 1'b0;
    I_pmem_address = '0;
    D_pmem_read    = 1'b0;
    D_pmem_write   = 1'b0;
    D_pmem_address = '0;
    D_pmem_wdata   = '0;
    pmem_resp      = 1'b0;
    pmem_rdata     = '0;

    // Reset state
    tick();
    tick();
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_pread", pmem_read, 1'b0);
    chk("rst_pwrite", pmem_write, 1'b0);
    chk("rst_paddr", pmem_address, 16'h0);
    chk("rst_pwdata", pmem_wdata, 128'h0);
    chk("rst_iresp", I_pmem_resp, 1'b0);
    chk("rst_dresp", D_pmem_resp, 1'b0);
    reset = 1'b0;
    tick();
    chk("idle_after_rst", dbg_state, S_IDLE);

    // Lone I read
    I_pmem_read    = 1'b1;
    I_pmem_address = 16'h1230;
    tick();
    chk("t1_state", dbg_state, S_BUSY_I);
    chk("t1_pread", pmem_read, 1'b1);
    chk("t1_pwrite", pmem_write, 1'b0);
    chk("t1_paddr", pmem_address, 16'h1230);
    chk("t1_iresp_early", I_pmem_resp, 1'b0);
    tick();
    chk("t1_paddr_hold", pmem_address, 16'h1230);
    pmem_rdata = line_a5;
    pmem_resp  = 1'b1;
    #1;
    chk("t1_iresp", I_pmem_resp, 1'b1);
    chk("t1_irdata", I_pmem_rdata, line_a5);
    chk("t1_dresp", D_pmem_resp, 1'b0);
    tick();
    chk("t1_release", dbg_state, S_RELEASE);
    chk("t1_pread_drop", pmem_read, 1'b0);
    pmem_resp   = 1'b0;
    I_pmem_read = 1'b0;
    tick();
    chk("t1_idle", dbg_state, S_IDLE);

    // Simultaneous I read and D write: D first, then I
    I_pmem_read    = 1'b1;
    I_pmem_address = 16'h0040;
    D_pmem_write   = 1'b1;
    D_pmem_address = 16'h0080;
    D_pmem_wdata   = line_db;
    tick();
    chk("t2_state_d", dbg_state, S_BUSY_D);
    chk("t2_pwrite", pmem_write, 1'b1);
    chk("t2_pread", pmem_read, 1'b0);
    chk("t2_paddr_d", pmem_address, 16'h0080);
    chk("t2_pwdata", pmem_wdata, line_db);
    pmem_resp = 1'b1;
    #1;
    chk("t2_dresp", D_pmem_resp, 1'b1);
    chk("t2_iresp_none", I_pmem_resp, 1'b0);
    tick();
    chk("t2_release", dbg_state, S_RELEASE);
    pmem_resp    = 1'b0;
    D_pmem_write = 1'b0;
    tick();
    chk("t2_idle", dbg_state, S_IDLE);
    tick();
    chk("t2_state_i", dbg_state, S_BUSY_I);
    chk("t2_pread_i", pmem_read, 1'b1);
    chk("t2_paddr_i", pmem_address, 16'h0040);
    pmem_resp = 1'b1;
    #1;
    chk("t2_iresp", I_pmem_resp, 1'b1);
    tick();
    pmem_resp   = 1'b0;
    I_pmem_read = 1'b0;
    tick();

    // Stray pmem_resp in IDLE is ignored
    pmem_resp = 1'b1;
    #1;
    chk("idle_resp_i", I_pmem_resp, 1'b0);
    chk("idle_resp_d", D_pmem_resp, 1'b0);
    tick();
    chk("idle_resp_state", dbg_state, S_IDLE);
    chk("idle_resp_pread", pmem_read, 1'b0);
    pmem_resp = 1'b0;

    // Starvation guard: I held, D issues back-to-back reads
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{S_BUSY_D, S_BUSY_I, S_BUSY_D, S_BUSY_I, S_BUSY_D};
`else
    exp_seq = '{S_BUSY_D, S_BUSY_D, S_BUSY_D, S_BUSY_I, S_BUSY_D};
`endif
    I_pmem_read    = 1'b1;
    I_pmem_address = 16'h0044;
    D_pmem_read    = 1'b1;
    D_pmem_address = 16'h0088;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("starve_grant%0d", g), dbg_state, exp_seq[g]);
      pmem_resp = 1'b1;
      #1;
      chk($sformatf("starve_iresp%0d", g), I_pmem_resp, exp_seq[g] == S_BUSY_I);
      chk($sformatf("starve_dresp%0d", g), D_pmem_resp, exp_seq[g] == S_BUSY_D);
      tick();
      pmem_resp = 1'b0;
      tick();
    end
    I_pmem_read = 1'b0;
    D_pmem_read = 1'b0;
    tick();
    tick();
    chk("starve_idle", dbg_state, S_IDLE);

    // Address stability during BUSY_D
    D_pmem_read    = 1'b1;
    D_pmem_address = 16'h0100;
    tick();
    chk("stab_state", dbg_state, S_BUSY_D);
    chk("stab_addr0", pmem_address, 16'h0100);
    D_pmem_address = 16'h0200;
    tick();
    chk("stab_addr1", pmem_address, 16'h0100);
    tick();
    chk("stab_addr2", pmem_address, 16'h0100);
    pmem_resp = 1'b1;
    #1;
    chk("stab_dresp", D_pmem_resp, 1'b1);
    tick();
    pmem_resp   = 1'b0;
    D_pmem_read = 1'b0;
    tick();

    // Request dropped during BUSY: transaction still completes
    I_pmem_read    = 1'b1;
    I_pmem_address = 16'h0600;
    tick();
    I_pmem_read = 1'b0;
    tick();
    chk("drop_state", dbg_state, S_BUSY_I);
    chk("drop_pread", pmem_read, 1'b1);
    pmem_resp = 1'b1;
    #1;
    chk("drop_iresp", I_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    tick();

    // Reset in the middle of BUSY_I
    I_pmem_read    = 1'b1;
    I_pmem_address = 16'h0500;
    tick();
    chk("rmid_pread_before", pmem_read, 1'b1);
    reset     = 1'b1;
    pmem_resp = 1'b1;
    #1;
    chk("rmid_pread", pmem_read, 1'b0);
    chk("rmid_state", dbg_state, S_IDLE);
    chk("rmid_iresp", I_pmem_resp, 1'b0);
    I_pmem_read = 1'b0;
    pmem_resp   = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Illegal D read+write: served as write, one resp pulse
    D_pmem_read    = 1'b1;
    D_pmem_write   = 1'b1;
    D_pmem_address = 16'h0300;
    D_pmem_wdata   = line_a5;
    tick();
    chk("ill_pwrite", pmem_write, 1'b1);
    chk("ill_pread", pmem_read, 1'b0);
    chk("ill_paddr", pmem_address, 16'h0300);
    pmem_resp = 1'b1;
    #1;
    chk("ill_dresp", D_pmem_resp, 1'b1);
    tick();
    chk("ill_release", dbg_state, S_RELEASE);
    chk("ill_dresp_once", D_pmem_resp, 1'b0);
    pmem_resp    = 1'b0;
    D_pmem_read  = 1'b0;
    D_pmem_write = 1'b0;
    tick();
    chk("ill_idle", dbg_state, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
